// File: rtl/xor_seq_pkg.sv
// Shared types, default sizes and helpers for the xor_design stimulus sequencer.
package xor_seq_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    sat_inc = (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/xor_seq_delay_pipe.sv
// Fixed-depth shift register carrying a valid bit alongside a data word.
module xor_seq_delay_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q [DEPTH];
  logic [W-1:0] data_q  [DEPTH];

  // Shift valid and data one stage per clock; reset discards contents.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/xor_stim_sequencer.sv
// Stimulus sweep and result checker for xor_design.
// Optional first-failure capture ports: define XOR_SEQ_FIRST_FAIL_CAPTURE_EN.
module xor_stim_sequencer
  import xor_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned DUT_LATENCY = 1,
  parameter int unsigned B_CONST     = 1,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_y,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count
`ifdef XOR_SEQ_FIRST_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_y
`endif
);

  localparam logic [WIDTH-1:0] B_VAL      = WIDTH'(B_CONST);
  localparam logic [7:0]       HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(DUT_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
`ifdef XOR_SEQ_FIRST_FAIL_CAPTURE_EN
  localparam int unsigned      PIPE_W     = 2 * WIDTH;
`else
  localparam int unsigned      PIPE_W     = WIDTH;
`endif

  seq_state_e       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       drain_q, drain_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic              start_ok;
  logic              strobe;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;
  logic              cmp_valid;
  logic [WIDTH-1:0]  cmp_gold;
  logic              cmp_fail;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign strobe   = (state_q == DRIVE) && (hold_q == HOLD_LAST);

`ifdef XOR_SEQ_FIRST_FAIL_CAPTURE_EN
  assign pipe_in = {a_q, a_q ^ b_q};
`else
  assign pipe_in = a_q ^ b_q;
`endif

  xor_seq_delay_pipe #(
    .DEPTH (DUT_LATENCY),
    .W     (PIPE_W)
  ) u_pipe (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (strobe),
    .data_i  (pipe_in),
    .valid_o (cmp_valid),
    .data_o  (pipe_out)
  );

  assign cmp_gold = pipe_out[WIDTH-1:0];
  assign cmp_fail = cmp_valid && (y != cmp_gold);

  // Sweep FSM and compare-counter next state.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          hold_d  = '0;
          drain_d = '0;
          a_d     = '0;
          b_d     = B_VAL;
        end
      end
      DRIVE: begin
        if (strobe) begin
          hold_d = '0;
          if (a_q == '1) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            a_d = a_q + WIDTH'(1);
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      pass_d = '0;
      err_d  = '0;
    end else if (cmp_valid) begin
      if (cmp_fail) begin
        err_d = CNT_W'(sat_inc(32'(err_q), 32'(CNT_MAX)));
      end else begin
        pass_d = CNT_W'(sat_inc(32'(pass_q), 32'(CNT_MAX)));
      end
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pass_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

`ifdef XOR_SEQ_FIRST_FAIL_CAPTURE_EN
  logic             fail_valid_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_y_q;

  // Latch operand and observed result of the first failing compare per sweep.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_y_q     <= '0;
    end else if (cmp_fail && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_a_q     <= pipe_out[PIPE_W-1:WIDTH];
      fail_y_q     <= y;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_y     = fail_y_q;
`endif

  assign a          = a_q;
  assign b          = b_q;
  assign exp_y      = cmp_gold;
  assign busy       = (state_q == DRIVE) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign mismatch   = cmp_fail;
  assign pass_count = pass_q;
  assign err_count  = err_q;

endmodule
